// File: rtl/wb_arb_pkg.sv
// Shared types for the WB write-port arbiter: data widths, FSM states and the
// queued MDU result entry.
package wb_arb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREGS  = 1 << REG_AW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    DRAIN   = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
    reg_onehot    = '0;
    reg_onehot[r] = 1'b1;
  endfunction

endpackage

// File: rtl/wb_arb_fifo.sv
// DEPTH-entry synchronous FIFO holding MDU results awaiting a regfile write slot.
// Pointers carry an extra MSB so full and empty are distinguishable.
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output wb_entry_t                head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  wb_entry_t   mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  always_comb begin
    count = wr_ptr - rd_ptr;
    empty = (wr_ptr == rd_ptr);
    full  = (count == (AW+1)'(DEPTH));
    head  = mem[rd_ptr[AW-1:0]];
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter between the WB stage and the MDU, with a result FIFO,
// anti-starvation drain and busy mask. Optional same-cycle MDU bypass: WB_BYPASS_EN.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_we,
  input  logic [REG_AW-1:0] pipe_rd,
  input  logic [XLEN-1:0]   pipe_data,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [REG_AW-1:0] mdu_rd,
  input  logic [XLEN-1:0]   mdu_data,
  output logic              stall_pipe,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_rd,
  output logic [XLEN-1:0]   rf_wdata,
  output logic [NREGS-1:0]  busy_mask
);

  localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  arb_state_e        state;
  arb_state_e        state_next;
  logic [AGE_W-1:0]  age;
  logic [AGE_W-1:0]  age_next;
  logic [NREGS-1:0]  busy_next;

  logic              pipe_wr;
  logic              mdu_fire;
  logic              bypass;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  wb_entry_t         fifo_head;
  wb_entry_t         push_entry;

  assign push_entry = '{rd: mdu_rd, data: mdu_data};

  wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .head       (fifo_head)
  );

  always_comb begin
    pipe_wr   = pipe_we && (pipe_rd != '0);
    mdu_ready = rst_n && !fifo_full && !busy_mask[mdu_rd];
    mdu_fire  = mdu_valid && mdu_ready;
  end

`ifdef WB_BYPASS_EN
  assign bypass = (state == IDLE) && !pipe_wr && mdu_fire;
`else
  assign bypass = 1'b0;
`endif

  // x0 results are acknowledged but never enter the queue.
  always_comb begin
    push = mdu_fire && (mdu_rd != '0) && !bypass;
    pop  = rst_n && !fifo_empty &&
           ((state == DRAIN) || ((state == PENDING) && !pipe_wr));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      age       <= '0;
      busy_mask <= '0;
    end else begin
      state     <= state_next;
      age       <= age_next;
      busy_mask <= busy_next;
    end
  end

  // DRAIN is entered on the edge where the blocked count reaches the limit.
  always_comb begin
    state_next = state;
    age_next   = age;
    unique case (state)
      IDLE: begin
        age_next = '0;
        if (push) state_next = PENDING;
      end
      PENDING: begin
        if (pipe_wr) begin
          age_next = age + AGE_W'(1);
          if (age_next == AGE_W'(STARVE_LIMIT)) state_next = DRAIN;
        end else begin
          age_next = '0;
          if ((fifo_count == CNT_W'(1)) && !push) state_next = IDLE;
        end
      end
      DRAIN: begin
        age_next   = '0;
        state_next = ((fifo_count > CNT_W'(1)) || push) ? PENDING : IDLE;
      end
      default: begin
        state_next = IDLE;
        age_next   = '0;
      end
    endcase
  end

  always_comb begin
    busy_next = busy_mask;
    if (pop)  busy_next = busy_next & ~reg_onehot(fifo_head.rd);
    if (push) busy_next = busy_next | reg_onehot(mdu_rd);
  end

  always_comb begin
    rf_we      = 1'b0;
    rf_rd      = pipe_rd;
    rf_wdata   = pipe_data;
    stall_pipe = 1'b0;
    unique case (state)
      IDLE: begin
        if (pipe_wr) begin
          rf_we = 1'b1;
        end else if (bypass && (mdu_rd != '0)) begin
          rf_we    = 1'b1;
          rf_rd    = mdu_rd;
          rf_wdata = mdu_data;
        end
      end
      PENDING: begin
        rf_we = 1'b1;
        if (!pipe_wr) begin
          rf_rd    = fifo_head.rd;
          rf_wdata = fifo_head.data;
        end
      end
      DRAIN: begin
        rf_we      = 1'b1;
        rf_rd      = fifo_head.rd;
        rf_wdata   = fifo_head.data;
        stall_pipe = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      rf_we      = 1'b0;
      stall_pipe = 1'b0;
    end
  end

endmodule
